// File: rtl/gate_pkg.sv
// Shared types, constants and the golden response function for the gate tester.
package gate_pkg;

    localparam int unsigned NUM_OUT = 7;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned ERR_MAX = 255;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    // Bit 0 is o1, bit 6 is o7.
    function automatic logic [NUM_OUT-1:0] gate_expect(input logic a, input logic b);
        return {~(a ^ b), ~(a & b), ~(a | b), a ^ b, a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/gate_tester_if.sv
// Stimulus/response bundle between the tester and the gate under test.
interface gate_tester_if;
    logic a;
    logic b;
    logic o1;
    logic o2;
    logic o3;
    logic o4;
    logic o5;
    logic o6;
    logic o7;

    modport master (output a, output b,
                    input o1, input o2, input o3, input o4, input o5, input o6, input o7);
    modport slave  (input a, input b,
                    output o1, output o2, output o3, output o4, output o5, output o6, output o7);
endinterface

// File: rtl/gate_golden.sv
// Combinational reference model of the seven-output gate block.
module gate_golden
    import gate_pkg::*;
(
    input  logic               a,
    input  logic               b,
    output logic [NUM_OUT-1:0] exp_out
);
    assign exp_out = gate_expect(a, b);
endmodule

// File: rtl/gate_tester.sv
// Sweeps all {a, b} vectors into the gate under test, compares responses against the
// golden model, and reports mismatch count plus the first failing vector and mask.
module gate_tester
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    gate_tester_if.master      gif,
    output logic               busy,
    output logic               done,
    output logic               pass_ok,
    output logic [7:0]         err_count,
    output logic [1:0]         first_fail_vec,
    output logic [NUM_OUT-1:0] first_fail_mask
);
    localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_e               state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [1:0]           ab_q, ab_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           err_q, err_d;
    logic [1:0]           ff_vec_q, ff_vec_d;
    logic [NUM_OUT-1:0]   ff_mask_q, ff_mask_d;
    logic                 pass_ok_q, pass_ok_d;
    logic [NUM_OUT-1:0]   exp_out;
    logic [NUM_OUT-1:0]   mism;

    gate_golden u_golden (
        .a       (ab_q[1]),
        .b       (ab_q[0]),
        .exp_out (exp_out)
    );

    assign mism = {gif.o7, gif.o6, gif.o5, gif.o4, gif.o3, gif.o2, gif.o1} ^ exp_out;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        ab_d      = ab_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ff_vec_d  = ff_vec_q;
        ff_mask_d = ff_mask_q;
        pass_ok_d = pass_ok_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSettle;
                    vec_d     = 2'd0;
                    ab_d      = 2'd0;
                    pass_d    = '0;
                    cnt_d     = '0;
                    err_d     = 8'd0;
                    ff_vec_d  = 2'd0;
                    ff_mask_d = '0;
                    pass_ok_d = 1'b0;
                end
            end
            StSettle: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCheck: begin
                busy = 1'b1;
                if (mism != '0) begin
                    if (err_q != 8'(ERR_MAX)) begin
                        err_d = err_q + 8'd1;
                    end
                    // A saturating count is nonzero exactly when a failure is recorded.
                    if (err_q == 8'd0) begin
                        ff_vec_d  = vec_q;
                        ff_mask_d = mism;
                    end
                end
                if (vec_q == 2'(NUM_VEC - 1) && pass_q == PASS_W'(PASSES - 1)) begin
                    state_d   = StDone;
                    ab_d      = 2'd0;
                    // Latched on entry so the verdict is already valid alongside done.
                    pass_ok_d = (err_d == 8'd0);
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + 2'd1;
                    ab_d    = vec_q + 2'd1;
                    cnt_d   = '0;
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        pass_d = pass_q + PASS_W'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            vec_q     <= 2'd0;
            ab_q      <= 2'd0;
            pass_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 8'd0;
            ff_vec_q  <= 2'd0;
            ff_mask_q <= '0;
            pass_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            ab_q      <= ab_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ff_vec_q  <= ff_vec_d;
            ff_mask_q <= ff_mask_d;
            pass_ok_q <= pass_ok_d;
        end
    end

    assign gif.a           = ab_q[1];
    assign gif.b           = ab_q[0];
    assign pass_ok         = pass_ok_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ff_vec_q;
    assign first_fail_mask = ff_mask_q;

endmodule
